testpattern_gen: RTL and testbench

// - Parametrised multi-pattern test-image generator for the N64 video path. Successor to the

---
 rtl/testpattern_gen.sv | 149 ++++++++++++++
 tb/tb_testpattern_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/testpattern_gen.sv
// Multi-pattern test-image generator: replaces pixel data with a selectable test pattern
// while passing the four sync lines through with one enabled cycle of latency.
module testpattern_gen #(
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned BAR_W       = 80,
    parameter logic [8:0]  VSTART_NTSC = 9'd20,
    parameter logic [8:0]  VSTOP_NTSC  = 9'd260,
    parameter logic [8:0]  VSTART_PAL  = 9'd30,
    parameter logic [8:0]  VSTOP_PAL   = 9'd300,
    parameter logic [9:0]  HSTART_NTSC = 10'd100,
    parameter logic [9:0]  HSTOP_NTSC  = 10'd740,
    parameter logic [9:0]  HSTART_PAL  = 10'd110,
    parameter logic [9:0]  HSTOP_PAL   = 10'd750
) (
    input  logic                     VCLK,
    input  logic                     RST,
    input  logic                     nVDSYNC,
    input  logic                     palmode,
    input  logic [1:0]               pattern_sel,
    input  logic [3*COLOR_W-1:0]     solid_rgb,
    input  logic [3:0]               Sync_in,
    output logic [4+3*COLOR_W-1:0]   vdata_out
);

    typedef enum logic [1:0] {
        PAT_CHECKER = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_GREY    = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_e;

    localparam int unsigned        BARC_W      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BARC_W-1:0]  BARPIX_LAST = BARC_W'(BAR_W - 1);
    localparam logic [BARC_W-1:0]  BARPIX_ONE  = BARC_W'(1);

    logic [9:0]              hcnt_q, hcnt_d;
    logic [8:0]              vcnt_q, vcnt_d;
    pat_e                    pat_q, pat_d;
    logic                    pal_q, pal_d;
    logic [2:0]              bar_q, bar_d;
    logic [BARC_W-1:0]       barpix_q, barpix_d;
    logic [4+3*COLOR_W-1:0]  vdata_q, vdata_d;

    logic                    en, neg_h, neg_v;
    logic [3:0]              sync_q;
    logic [9:0]              hstart, hstop, x;
    logic [8:0]              vstart, vstop;
    logic                    active;
    logic [COLOR_W-1:0]      grey;
    logic [3*COLOR_W-1:0]    rgb;

    assign en     = ~nVDSYNC;
    assign sync_q = vdata_q[3*COLOR_W +: 4];
    assign neg_h  = sync_q[1] & ~Sync_in[1];
    assign neg_v  = sync_q[3] & ~Sync_in[3];

    assign hstart = pal_q ? HSTART_PAL : HSTART_NTSC;
    assign hstop  = pal_q ? HSTOP_PAL  : HSTOP_NTSC;
    assign vstart = pal_q ? VSTART_PAL : VSTART_NTSC;
    assign vstop  = pal_q ? VSTOP_PAL  : VSTOP_NTSC;
    assign x      = hcnt_q - hstart;
    assign active = (vcnt_q >= vstart) && (vcnt_q < vstop) &&
                    (hcnt_q >= hstart) && (hcnt_q < hstop);

    if (COLOR_W <= 10) begin : g_grey_lsb
        assign grey = x[COLOR_W-1:0];
    end else begin : g_grey_pad
        assign grey = {x, {(COLOR_W-10){1'b0}}};
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            pat_q    <= PAT_CHECKER;
            pal_q    <= 1'b0;
            bar_q    <= '0;
            barpix_q <= '0;
            vdata_q  <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            pat_q    <= pat_d;
            pal_q    <= pal_d;
            bar_q    <= bar_d;
            barpix_q <= barpix_d;
            vdata_q  <= vdata_d;
        end
    end

    always_comb begin
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        pat_d    = pat_q;
        pal_d    = pal_q;
        bar_d    = bar_q;
        barpix_d = barpix_q;
        vdata_d  = vdata_q;
        if (en) begin
            if (neg_h)
                hcnt_d = '0;
            else if (hcnt_q != '1)
                hcnt_d = hcnt_q + 10'd1;

            if (neg_v)
                vcnt_d = '0;
            else if (neg_h && (vcnt_q != '1))
                vcnt_d = vcnt_q + 9'd1;

            if (neg_v) begin
                pat_d = pat_e'(pattern_sel);
                pal_d = palmode;
            end

            // Bar state tracks the pixel the counter moves to, so it lines up with hcnt_q.
            if (hcnt_d == (pal_d ? HSTART_PAL : HSTART_NTSC)) begin
                bar_d    = '0;
                barpix_d = '0;
            end else if (hcnt_d != hcnt_q) begin
                if (barpix_q == BARPIX_LAST) begin
                    barpix_d = '0;
                    if (bar_q != 3'd7)
                        bar_d = bar_q + 3'd1;
                end else begin
                    barpix_d = barpix_q + BARPIX_ONE;
                end
            end

            vdata_d = {Sync_in, rgb};
        end
    end

    // Bar colours decode directly from the index bits (white..black order).
    always_comb begin
        rgb = '0;
        case (pat_q)
            PAT_CHECKER: if (x[0] ^ vcnt_q[0]) rgb = '1;
            PAT_BARS:    rgb = {{COLOR_W{~bar_q[1]}}, {COLOR_W{~bar_q[2]}}, {COLOR_W{~bar_q[0]}}};
            PAT_GREY:    rgb = {grey, grey, grey};
            PAT_SOLID:   rgb = solid_rgb;
            default:     rgb = '0;
        endcase
        if (!active)
            rgb = '0;
    end

    assign vdata_out = vdata_q;

endmodule

// File: tb/tb_testpattern_gen.sv
// Directed bench for testpattern_gen: walks hcnt/vcnt with synthetic sync pulses and
// compares vdata_out against hand-computed pixel values.
module tb_testpattern_gen;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 4 + 3*CW;

    logic          VCLK        = 1'b0;
    logic          RST         = 1'b1;
    logic          nVDSYNC     = 1'b0;
    logic          palmode     = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic [3*CW-1:0] solid_rgb = 24'h123456;
    logic [3:0]    Sync_in     = 4'hF;
    logic [DW-1:0] vdata_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          hpos     = 0;
    int unsigned nonblack;

    always #5 VCLK = ~VCLK;

    testpattern_gen #(
        .COLOR_W(CW),
        .BAR_W  (80)
    ) dut (
        .VCLK       (VCLK),
        .RST        (RST),
        .nVDSYNC    (nVDSYNC),
        .palmode    (palmode),
        .pattern_sel(pattern_sel),
        .solid_rgb  (solid_rgb),
        .Sync_in    (Sync_in),
        .vdata_out  (vdata_out)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [3:0] s);
        Sync_in = s;
        nVDSYNC = 1'b0;
        @(posedge VCLK);
        #1;
    endtask

    task automatic hsync();
        tick(4'hD);
        tick(4'hF);
        hpos = 1;
    endtask

    task automatic hsyncs(input int n);
        for (int i = 0; i < n; i++) hsync();
    endtask

    task automatic vsync();
        tick(4'h7);
        tick(4'hF);
    endtask

    task automatic seek(input int h);
        while (hpos < h) begin
            tick(4'hF);
            hpos++;
        end
    endtask

    // One more enabled cycle after hcnt reaches h exposes that pixel on vdata_out.
    task automatic look(input int h, input string tag, input logic [DW-1:0] exp);
        seek(h);
        tick(4'hF);
        hpos++;
        check_eq(tag, vdata_out, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge VCLK);
        #1;
        check_eq("rst_out", vdata_out, 28'h0000000);
        RST = 1'b0;
        tick(4'hF);
        check_eq("rst_release", vdata_out, 28'hF000000);

        // Checkerboard, NTSC
        vsync();
        hsyncs(19);
        look(101, "ck_v19", 28'hF000000);
        hsync();
        look(100, "ck_20_100", 28'hF000000);
        look(101, "ck_20_101", 28'hFFFFFFF);
        look(739, "ck_20_739", 28'hFFFFFFF);
        look(740, "ck_20_740", 28'hF000000);
        hsync();
        look(100, "ck_21_100", 28'hFFFFFFF);
        look(101, "ck_21_101", 28'hF000000);

        // Mid-frame change must not take effect until the next vsync
        pattern_sel = 2'd3;
        palmode     = 1'b1;
        solid_rgb   = 24'hA5C33C;
        hsync();
        look(101, "latch_hold_a", 28'hFFFFFFF);
        hsync();
        look(100, "latch_hold_b", 28'hFFFFFFF);

        vsync();
        hsyncs(29);
        look(110, "pal_v29", 28'hF000000);
        hsync();
        look(109, "pal_h109", 28'hF000000);
        look(110, "solid_110", 28'hFA5C33C);
        solid_rgb = 24'h0F1E2D;
        look(111, "solid_live", 28'hF0F1E2D);
        look(749, "solid_749", 28'hF0F1E2D);
        look(750, "pal_h750", 28'hF000000);

        // Colour bars
        pattern_sel = 2'd1;
        palmode     = 1'b0;
        vsync();
        hsyncs(20);
        look(100, "bar_white", 28'hFFFFFFF);
        look(179, "bar_white_end", 28'hFFFFFFF);
        look(180, "bar_yellow", 28'hFFFFF00);
        look(260, "bar_cyan", 28'hF00FFFF);
        look(420, "bar_magenta", 28'hFFF00FF);
        look(659, "bar_blue", 28'hF0000FF);
        look(739, "bar_black", 28'hF000000);

        // Grey ramp with a stall in the middle
        pattern_sel = 2'd2;
        vsync();
        hsyncs(20);
        look(100, "grey_100", 28'hF000000);
        look(228, "grey_228", 28'hF808080);
        nVDSYNC = 1'b1;
        Sync_in = 4'h0;
        repeat (5) @(posedge VCLK);
        #1;
        check_eq("stall_hold", vdata_out, 28'hF808080);
        look(229, "stall_resume", 28'hF818181);
        look(355, "grey_355", 28'hFFFFFFF);
        look(356, "grey_356", 28'hF000000);

        // nHSYNC and nVSYNC fall together: vcnt must end at 0, not 1
        pattern_sel = 2'd0;
        tick(4'h5);
        tick(4'hF);
        hsyncs(20);
        look(101, "collide_v", 28'hFFFFFFF);
        hsync();

        // Reset mid-frame with nVDSYNC high: counters restart at 0
        RST     = 1'b1;
        nVDSYNC = 1'b1;
        @(posedge VCLK);
        #1;
        check_eq("rst_mid", vdata_out, 28'h0000000);
        RST = 1'b0;
        tick(4'hF);
        hsyncs(20);
        look(101, "rst_mid_v", 28'hFFFFFFF);

        // hcnt saturates without hsync; no wrap back into the window
        seek(760);
        nonblack = 0;
        for (int i = 0; i < 1400; i++) begin
            tick(4'hF);
            if (vdata_out[3*CW-1:0] != '0) nonblack++;
        end
        check_eq("hsat", DW'(nonblack), '0);

        // vcnt saturates at 511 without vsync
        hsyncs(600);
        look(101, "vsat", 28'hF000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
